d_ram_arbiter: RTL and testbench

- Shares the single data RAM (one write port, one read port, 1-cycle registered read) between two requesters.
- Master 0 is the CPU load/store unit; master 1 is the DMA/UART loader.
- Exploits the RAM's independent ports: one master's write and the other master's read issue in the same cycle.
- Conflicts are resolved round-robin, or by fixed priority when configured.
- Sits between the masters and the data RAM; the RAM connects directly to the ram_* ports.

---
 rtl/d_ram_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 44 ++++
 rtl/d_ram_arbiter.sv | 108 ++++++++++
 tb/tb_d_ram_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/d_ram_pkg.sv
// Shared definitions for the data RAM arbiter: default geometry and master indices.
package d_ram_pkg;

  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_DATA_WIDTH = 8;

  localparam int M_CPU = 0;
  localparam int M_DMA = 1;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  // The master that did not win last time gets the next conflict.
  function automatic owner_e other_owner(input owner_e who);
    return (who == OWN_CPU) ? OWN_DMA : OWN_CPU;
  endfunction

  function automatic logic [1:0] owner_onehot(input owner_e who);
    return (who == OWN_CPU) ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input conflict arbiter holding the last-winner register.
// Non-conflicting requests pass straight through; conflicts pick one winner.
module rr_arb2
  import d_ram_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       conflict,
  output logic [1:0] win
);

  owner_e last;
  owner_e conflict_winner;
  logic   contested;

  assign contested = conflict & req[M_CPU] & req[M_DMA];

  always_comb begin
    conflict_winner = other_owner(last);
    if (FIXED_PRIO) begin
      conflict_winner = OWN_CPU;
    end
  end

  always_comb begin
    win = req;
    if (contested) begin
      win = owner_onehot(conflict_winner);
    end
  end

  // Pointer only moves on contested cycles so uncontended traffic never shifts fairness.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= OWN_DMA;
    end else if (contested) begin
      last <= conflict_winner;
    end
  end

endmodule

// File: rtl/d_ram_arbiter.sv
// Shares the dual-port data RAM between the CPU (master 0) and DMA loader (master 1),
// steering grants onto the write and read ports and routing registered read data back.
module d_ram_arbiter
  import d_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  output logic                  ram_w_en,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_r_en,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  logic [1:0] req;
  logic [1:0] win;
  logic       conflict;
  logic       wr0, wr1, rd0, rd1;
  logic       rvalid_q;
  owner_e     owner_q;

  assign req = {m1_req, m0_req} & {2{~rst}};

  // Same-type accesses share a RAM port; a read and write to one address would
  // return pre-write data, so those are serialised as well.
  assign conflict = m0_req & m1_req &
                    ((m0_we == m1_we) | (m0_addr == m1_addr));

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .conflict(conflict),
    .win     (win)
  );

  assign m0_gnt = win[M_CPU];
  assign m1_gnt = win[M_DMA];

  assign wr0 = m0_gnt & m0_we;
  assign wr1 = m1_gnt & m1_we;
  assign rd0 = m0_gnt & ~m0_we;
  assign rd1 = m1_gnt & ~m1_we;

  always_comb begin
    ram_w_en   = wr0 | wr1;
    ram_w_addr = '0;
    ram_din    = '0;
    if (wr0) begin
      ram_w_addr = m0_addr;
      ram_din    = m0_wdata;
    end else if (wr1) begin
      ram_w_addr = m1_addr;
      ram_din    = m1_wdata;
    end
  end

  always_comb begin
    ram_r_en   = rd0 | rd1;
    ram_r_addr = '0;
    if (rd0) begin
      ram_r_addr = m0_addr;
    end else if (rd1) begin
      ram_r_addr = m1_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      owner_q  <= OWN_CPU;
    end else begin
      rvalid_q <= rd0 | rd1;
      owner_q  <= rd1 ? OWN_DMA : OWN_CPU;
    end
  end

  // Gating with rst drops a return whose grant preceded a reset assertion.
  assign m0_rvalid = rvalid_q & ~rst & (owner_q == OWN_CPU);
  assign m1_rvalid = rvalid_q & ~rst & (owner_q == OWN_DMA);
  assign m0_rdata  = m0_rvalid ? ram_dout : '0;
  assign m1_rdata  = m1_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_d_ram_arbiter.sv
// Directed bench for d_ram_arbiter: vector table plus hand-written fairness sequence,
// with a round-robin instance (a) and a fixed-priority instance (b) each on its own RAM model.
module tb_d_ram_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;

  logic          a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
  logic [DW-1:0] a_m0_rdata, a_m1_rdata;
  logic          a_w_en, a_r_en;
  logic [AW-1:0] a_w_addr, a_r_addr;
  logic [DW-1:0] a_din, a_dout;

  logic          b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic [DW-1:0] b_m0_rdata, b_m1_rdata;
  logic          b_w_en, b_r_en;
  logic [AW-1:0] b_w_addr, b_r_addr;
  logic [DW-1:0] b_din, b_dout;

  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];

  int compared;
  int mismatched;

  d_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1'b0)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .ram_w_en(a_w_en), .ram_w_addr(a_w_addr), .ram_din(a_din),
    .ram_r_en(a_r_en), .ram_r_addr(a_r_addr), .ram_dout(a_dout)
  );

  d_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1'b1)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .ram_w_en(b_w_en), .ram_w_addr(b_w_addr), .ram_din(b_din),
    .ram_r_en(b_r_en), .ram_r_addr(b_r_addr), .ram_dout(b_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM models: one write port, one registered read port.
  always @(posedge clk) begin
    if (a_w_en) mem_a[a_w_addr] <= a_din;
    if (a_r_en) a_dout <= mem_a[a_r_addr];
    if (b_w_en) mem_b[b_w_addr] <= b_din;
    if (b_r_en) b_dout <= mem_b[b_r_addr];
  end

  typedef struct {
    logic          rst;
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          g0, g1, v0;
    logic [DW-1:0] q0;
    logic          v1;
    logic [DW-1:0] q1;
    logic          ew, er;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic rs,
    input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic g0, input logic g1,
    input logic v0, input logic [DW-1:0] q0, input logic v1, input logic [DW-1:0] q1,
    input logic ew, input logic er);
    vec_t v;
    v.rst = rs;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.q0 = q0; v.v1 = v1; v.q1 = q1;
    v.ew = ew; v.er = er;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst      = v.rst;
    m0_req   = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req   = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  int cnt_a0, cnt_a1, cnt_b0, cnt_b1;

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < (1<<AW); i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[11'h021] = 8'h77; mem_b[11'h021] = 8'h77;
    mem_a[11'h040] = 8'h11; mem_b[11'h040] = 8'h11;

    //          rst r0 w0 a0       d0     r1 w1 a1       d1     g0 g1 v0 q0     v1 q1     ew er
    vecs[0]  = mk(1, 1, 1, 11'h010, 8'h5A, 1, 0, 11'h021, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    vecs[1]  = mk(1, 0, 0, 11'h000, 8'h00, 0, 0, 11'h000, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    vecs[2]  = mk(0, 1, 1, 11'h010, 8'h5A, 0, 0, 11'h000, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 1, 0);
    vecs[3]  = mk(0, 1, 0, 11'h010, 8'h00, 0, 0, 11'h000, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1);
    vecs[4]  = mk(0, 0, 0, 11'h000, 8'h00, 0, 0, 11'h000, 8'h00, 0, 0, 1, 8'h5A, 0, 8'h00, 0, 0);
    vecs[5]  = mk(0, 1, 1, 11'h020, 8'h33, 1, 0, 11'h021, 8'h00, 1, 1, 0, 8'h00, 0, 8'h00, 1, 1);
    vecs[6]  = mk(0, 0, 0, 11'h000, 8'h00, 0, 0, 11'h000, 8'h00, 0, 0, 0, 8'h00, 1, 8'h77, 0, 0);
    vecs[7]  = mk(0, 1, 1, 11'h040, 8'hAA, 1, 0, 11'h040, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 1, 0);
    vecs[8]  = mk(0, 0, 0, 11'h000, 8'h00, 1, 0, 11'h040, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1);
    vecs[9]  = mk(0, 0, 0, 11'h000, 8'h00, 0, 0, 11'h000, 8'h00, 0, 0, 0, 8'h00, 1, 8'hAA, 0, 0);
    vecs[10] = mk(0, 0, 0, 11'h000, 8'h00, 1, 0, 11'h021, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1);
    vecs[11] = mk(1, 1, 0, 11'h010, 8'h00, 0, 0, 11'h000, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    vecs[12] = mk(0, 1, 1, 11'h7FF, 8'h01, 1, 1, 11'h7FF, 8'h02, 1, 0, 0, 8'h00, 0, 8'h00, 1, 0);
    vecs[13] = mk(0, 0, 0, 11'h000, 8'h00, 1, 1, 11'h7FF, 8'h02, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0);
    vecs[14] = mk(0, 1, 0, 11'h7FF, 8'h00, 0, 0, 11'h000, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1);
    vecs[15] = mk(0, 0, 0, 11'h000, 8'h00, 0, 0, 11'h000, 8'h00, 0, 0, 1, 8'h02, 0, 8'h00, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #2;
      checkOutput("m0_gnt",    i, 32'(a_m0_gnt),    32'(vecs[i].g0));
      checkOutput("m1_gnt",    i, 32'(a_m1_gnt),    32'(vecs[i].g1));
      checkOutput("m0_rvalid", i, 32'(a_m0_rvalid), 32'(vecs[i].v0));
      checkOutput("m0_rdata",  i, 32'(a_m0_rdata),  32'(vecs[i].q0));
      checkOutput("m1_rvalid", i, 32'(a_m1_rvalid), 32'(vecs[i].v1));
      checkOutput("m1_rdata",  i, 32'(a_m1_rdata),  32'(vecs[i].q1));
      checkOutput("ram_w_en",  i, 32'(a_w_en),      32'(vecs[i].ew));
      checkOutput("ram_r_en",  i, 32'(a_r_en),      32'(vecs[i].er));
    end

    // Fairness: reset the pointer, then both masters read every cycle.
    @(negedge clk);
    rst = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0;
    #2;
    checkOutput("rst_gnt0", 100, 32'(a_m0_gnt), 32'd0);
    checkOutput("rst_gnt1", 100, 32'(a_m1_gnt), 32'd0);

    cnt_a0 = 0; cnt_a1 = 0; cnt_b0 = 0; cnt_b1 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rst = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'h010; m0_wdata = '0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'h021; m1_wdata = '0;
      #2;
      cnt_a0 += int'(a_m0_gnt); cnt_a1 += int'(a_m1_gnt);
      cnt_b0 += int'(b_m0_gnt); cnt_b1 += int'(b_m1_gnt);
      checkOutput("rr_gnt0", 200 + k, 32'(a_m0_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("rr_gnt1", 200 + k, 32'(a_m1_gnt), (k % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput("rr_rvalid0", 200 + k, 32'(a_m0_rvalid), (k > 0 && k % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput("rr_rvalid1", 200 + k, 32'(a_m1_rvalid), (k > 0 && k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("rr_rdata0", 200 + k, 32'(a_m0_rdata), (k > 0 && k % 2 == 1) ? 32'h5A : 32'h0);
      checkOutput("rr_rdata1", 200 + k, 32'(a_m1_rdata), (k > 0 && k % 2 == 0) ? 32'h77 : 32'h0);
      checkOutput("fp_gnt0", 200 + k, 32'(b_m0_gnt), 32'd1);
      checkOutput("fp_gnt1", 200 + k, 32'(b_m1_gnt), 32'd0);
      checkOutput("fp_rdata0", 200 + k, 32'(b_m0_rdata), (k > 0) ? 32'h5A : 32'h0);
      checkOutput("fp_rvalid1", 200 + k, 32'(b_m1_rvalid), 32'd0);
    end

    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    #2;
    checkOutput("rr_tail_rvalid1", 300, 32'(a_m1_rvalid), 32'd1);
    checkOutput("rr_tail_rdata1",  300, 32'(a_m1_rdata),  32'h77);
    checkOutput("rr_tail_rvalid0", 300, 32'(a_m0_rvalid), 32'd0);
    checkOutput("rr_count0", 301, 32'(cnt_a0), 32'd4);
    checkOutput("rr_count1", 301, 32'(cnt_a1), 32'd4);
    checkOutput("fp_count0", 301, 32'(cnt_b0), 32'd8);
    checkOutput("fp_count1", 301, 32'(cnt_b1), 32'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
